// File: rtl/trivium_cipher_top.sv
// rtl/trivium_cipher_top.sv - Trivium keystream generator on the TinyTapeout pinout
// Byte-serial key/IV load, warm-up on start, one keystream byte per next command.
module trivium_cipher_top #(
    parameter int INIT_ROUNDS = 1152
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = ($clog2(INIT_ROUNDS) > 4) ? $clog2(INIT_ROUNDS) : 4;
    localparam logic [CW-1:0] LAST_INIT = CW'(INIT_ROUNDS - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(7);
    localparam logic [0:0] MODE_INIT = 1'b0;
    localparam logic [0:0] MODE_BYTE = 1'b1;

    logic         wr_key, wr_iv, cmd_start, cmd_next;
    logic         unused_uio;
    logic [79:0]  key_q, key_d, iv_q, iv_d;
    logic [287:0] s_q, s_d, s_upd;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]   mode_q, mode_d;
    logic         busy_q, busy_d, ready_q, ready_d, bv_q, bv_d;
    logic [7:0]   acc_q, acc_d, uo_q, uo_d;
    logic         t1, t2, t3, z, t1n, t2n, t3n;

    assign wr_key     = uio_in[0];
    assign wr_iv      = uio_in[1];
    assign cmd_start  = uio_in[2];
    assign cmd_next   = uio_in[3];
    assign unused_uio = ^uio_in[7:4];

    // Bit s_n of the cipher state lives at s_q[n-1].
    assign t1  = s_q[65] ^ s_q[92];
    assign t2  = s_q[161] ^ s_q[176];
    assign t3  = s_q[242] ^ s_q[287];
    assign z   = t1 ^ t2 ^ t3;
    assign t1n = t1 ^ (s_q[90] & s_q[91]) ^ s_q[170];
    assign t2n = t2 ^ (s_q[174] & s_q[175]) ^ s_q[263];
    assign t3n = t3 ^ (s_q[285] & s_q[286]) ^ s_q[68];
    assign s_upd = {s_q[286:177], t2n, s_q[175:93], t1n, s_q[91:0], t3n};

    always_comb begin
        key_d  = key_q;
        iv_d   = iv_q;
        s_d    = s_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        busy_d = busy_q;
        ready_d = ready_q;
        bv_d   = bv_q;
        acc_d  = acc_q;
        uo_d   = uo_q;
        if (ena) begin
            if (!busy_q) begin
                if (wr_key) key_d = {ui_in, key_q[79:8]};
                if (wr_iv)  iv_d  = {ui_in, iv_q[79:8]};
                if (cmd_start) begin
                    s_d           = '0;
                    s_d[79:0]     = key_q;
                    s_d[172:93]   = iv_q;
                    s_d[287:285]  = 3'b111;
                    cnt_d   = '0;
                    mode_d  = MODE_INIT;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    bv_d    = 1'b0;
                end else if (cmd_next && ready_q) begin
                    cnt_d  = '0;
                    mode_d = MODE_BYTE;
                    busy_d = 1'b1;
                    bv_d   = 1'b0;
                end
            end else begin
                s_d   = s_upd;
                cnt_d = cnt_q + 1'b1;
                acc_d = {z, acc_q[7:1]};
                if (mode_q == MODE_BYTE) begin
                    if (cnt_q == LAST_BIT) begin
                        busy_d = 1'b0;
                        bv_d   = 1'b1;
                        uo_d   = {z, acc_q[7:1]};
                    end
                end else if (cnt_q == LAST_INIT) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            iv_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_INIT;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            bv_q    <= 1'b0;
            acc_q   <= '0;
            uo_q    <= '0;
        end else begin
            key_q   <= key_d;
            iv_q    <= iv_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            bv_q    <= bv_d;
            acc_q   <= acc_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {1'b0, bv_q, ready_q, busy_q, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_trivium_cipher_top.sv
// tb/tb_trivium_cipher_top.sv - directed bench for trivium_cipher_top
module tb_trivium_cipher_top;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int passed = 0;
    int total = 0;

    logic [7:0] key_bytes [10];
    logic [7:0] iv_bytes [10];
    logic [7:0] exp_bytes [16];
    logic [7:0] got_bytes [16];
    logic [7:0] ref_bytes [16];

    trivium_cipher_top #(.INIT_ROUNDS(1152)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model indexed exactly as the cipher is written: s[1..288].
    task automatic model_run();
        bit s [1:288];
        bit t1, t2, t3, z;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 8; j++) begin
                s[8*i+j+1]    = key_bytes[i][j];
                s[93+8*i+j+1] = iv_bytes[i][j];
            end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + 128; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = t3;
            if (r >= 1152) exp_bytes[(r-1152)/8][(r-1152)%8] = z;
        end
    endtask

    task automatic load_regs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ui_in = key_bytes[i]; uio_in = 8'h01;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ui_in = iv_bytes[i]; uio_in = 8'h02;
        end
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    // Counts busy cycles; optionally pauses ena or injects wr_key+start mid-run.
    task automatic wait_busy(input int drop_at, input int inject_at, output int cycles);
        cycles = 0;
        while (uio_out[4] && cycles < 5000) begin
            cycles++;
            if (cycles == drop_at) ena = 1'b0;
            if (cycles == drop_at + 50) ena = 1'b1;
            if (cycles == inject_at) begin ui_in = 8'h55; uio_in = 8'h05; end
            else if (cycles == inject_at + 1) uio_in = 8'h00;
            @(negedge clk);
        end
        ena = 1'b1;
        uio_in = 8'h00;
    endtask

    task automatic do_start(input int drop_at, input int inject_at, output int cycles);
        @(negedge clk);
        uio_in = 8'h04;
        @(negedge clk);
        uio_in = 8'h00;
        wait_busy(drop_at, inject_at, cycles);
    endtask

    task automatic get_byte(input int drop_at, output logic [7:0] b, output int lat);
        uio_in = 8'h08;
        @(negedge clk);
        uio_in = 8'h00;
        wait_busy(drop_at, -10, lat);
        b = uo_out;
    endtask

    task automatic get_bytes(input int n, output int bad_lat);
        int lat;
        bad_lat = 0;
        for (int i = 0; i < n; i++) begin
            get_byte(-100, got_bytes[i], lat);
            if (lat != 8 || !uio_out[6]) bad_lat++;
        end
    endtask

    task automatic set_key_iv(input logic [7:0] k0, input logic iv_count);
        for (int i = 0; i < 10; i++) begin
            key_bytes[i] = 8'h00;
            iv_bytes[i]  = iv_count ? 8'(i + 1) : 8'h00;
        end
        key_bytes[0] = k0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (uo_out !== 8'h00) $display("FAIL reset_uo got %h want 00", uo_out); else passed++;
        total++; if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out); else passed++;
        total++; if (uio_oe !== 8'hF0) $display("FAIL reset_oe got %h want f0", uio_oe); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        uio_in = 8'h08;
        repeat (3) @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
        total++; if (uio_out !== 8'h00) $display("FAIL next_before_start uio got %h want 00", uio_out); else passed++;
    endtask

    task automatic test_zero_key();
        int cyc, bad;
        set_key_iv(8'h00, 1'b0);
        model_run();
        load_regs();
        do_start(-100, -10, cyc);
        total++; if (cyc != 1152) $display("FAIL init_cycles got %0d want 1152", cyc); else passed++;
        total++; if (uio_out !== 8'h20) $display("FAIL ready_flags got %h want 20", uio_out); else passed++;
        get_bytes(16, bad);
        total++; if (bad != 0) $display("FAIL byte_latency got %0d bad want 0", bad); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL zero_key_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
    endtask

    task automatic test_key80_ivs();
        int cyc, bad, diff;
        set_key_iv(8'h80, 1'b0);
        model_run();
        load_regs();
        do_start(-100, -10, cyc);
        get_bytes(16, bad);
        for (int i = 0; i < 16; i++) begin
            ref_bytes[i] = got_bytes[i];
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL key80_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
        set_key_iv(8'h80, 1'b1);
        model_run();
        load_regs();
        do_start(-100, -10, cyc);
        get_bytes(16, bad);
        diff = 0;
        for (int i = 0; i < 16; i++) begin
            if (got_bytes[i] !== ref_bytes[i]) diff++;
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL key80_iv_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
        total++; if (diff == 0) $display("FAIL iv_changes_stream got %0d differing want >0", diff); else passed++;
    endtask

    task automatic test_hold_and_busy_writes();
        int cyc, bad;
        set_key_iv(8'h00, 1'b1);
        key_bytes[0] = 8'h11; key_bytes[5] = 8'h3C; key_bytes[9] = 8'hC5;
        load_regs();
        @(negedge clk);
        ui_in = 8'hAA; uio_in = 8'h01;
        repeat (3) @(negedge clk);
        uio_in = 8'h00;
        for (int i = 0; i < 7; i++) key_bytes[i] = key_bytes[i+3];
        for (int i = 7; i < 10; i++) key_bytes[i] = 8'hAA;
        model_run();
        do_start(-100, 400, cyc);
        total++; if (cyc != 1152) $display("FAIL busy_inject_cycles got %0d want 1152", cyc); else passed++;
        get_bytes(4, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL hold_wr_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
        do_start(-100, -10, cyc);
        get_bytes(2, bad);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL restart_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
    endtask

    task automatic test_ena_pause();
        int cyc, lat, bad;
        logic [7:0] b;
        set_key_iv(8'h80, 1'b1);
        model_run();
        load_regs();
        do_start(500, -10, cyc);
        total++; if (cyc != 1202) $display("FAIL ena_init_cycles got %0d want 1202", cyc); else passed++;
        get_bytes(1, bad);
        total++; if (got_bytes[0] !== exp_bytes[0]) $display("FAIL ena_byte0 got %h want %h", got_bytes[0], exp_bytes[0]); else passed++;
        get_byte(3, b, lat);
        total++; if (lat != 58) $display("FAIL ena_byte_latency got %0d want 58", lat); else passed++;
        total++; if (b !== exp_bytes[1]) $display("FAIL ena_byte1 got %h want %h", b, exp_bytes[1]); else passed++;
    endtask

    task automatic test_reset_mid_byte();
        int cyc, bad;
        uio_in = 8'h08;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (uo_out !== 8'h00) $display("FAIL midrst_uo got %h want 00", uo_out); else passed++;
        total++; if (uio_out !== 8'h00) $display("FAIL midrst_uio got %h want 00", uio_out); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        load_regs();
        do_start(-100, -10, cyc);
        get_bytes(3, bad);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_bytes[i] !== exp_bytes[i])
                $display("FAIL after_reset_byte%0d got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_key80_ivs();
        test_hold_and_busy_writes();
        test_ena_pause();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
